mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares the single 16-bit valid/ready memory port (byte-banked RAM at 0xB000, MMIO at 0xFFFE)
//  between two bus masters: m0 = core, m1 = loader/debug master. One transaction in flight,
//  round-robin on contention, per-transaction timeout so a dead slave cannot hang a master.
// PARAMETERS
//  ADDR_W      16  address width
//  DATA_W      16  data width
//  STRB_W      2   write-strobe width (bit1 = halfword, bit0 = byte; 0 = read)
//  TIMEOUT     64  cycles in BUSY before abort; 0 disables timeout
// PORTS
//  clk        in   1       clock
//  rst        in   1       reset, synchronous, active-high
//  m0_valid   in   1       core request; held with addr/wdata/wstrb until m0_ready
//  m0_addr    in   ADDR_W  core address
//  m0_wdata   in   DATA_W  core write data
//  m0_wstrb   in   STRB_W  core write strobe
//  m0_ready   out  1       one-cycle completion pulse to core
//  m0_rdata   out  DATA_W  read data, valid when m0_ready
//  m0_err     out  1       with m0_ready: transaction timed out
//  m1_*       same set as m0_* for the loader master
//  s_valid    out  1       request to memory slave
//  s_addr     out  ADDR_W  slave address
//  s_wdata    out  DATA_W  slave write data
//  s_wstrb    out  STRB_W  slave write strobe
//  s_ready    in   1       slave one-cycle completion pulse
//  s_rdata    in   DATA_W  slave read data, valid with s_ready
//  grant      out  2       one-hot owner of current transaction (status/debug)
// BEHAVIOUR
//  - States: IDLE, BUSY. Reset -> IDLE, grant=0, last=1, timeout count=0; all outputs 0.
//  - IDLE: if any mX_valid, register winner into grant and go BUSY next edge. Only m0 -> m0;
//    only m1 -> m1; both -> master != last. last updates on every grant.
//  - BUSY: s_valid=1; s_addr/s_wdata/s_wstrb = granted master's inputs (combinational mux).
//  - IDLE: s_valid=0 and s_addr/s_wdata/s_wstrb driven 0 (slave samples nonzero wstrb as a write).
//  - s_ready in BUSY: mX_ready=1 combinationally for granted master only, mX_rdata=s_rdata,
//    mX_err=0; next edge -> IDLE, grant=0. s_ready outside BUSY ignored.
//  - Latency: request seen cycle N -> s_valid at N+1; slave ready at N+2 (1-cycle RAM) ->
//    master ready at N+2. Back-to-back: next grant decided in the IDLE cycle after completion.
//  - Timeout: counter clears on entry to BUSY, increments each BUSY cycle without s_ready;
//    at count==TIMEOUT-1 and no s_ready: mX_ready=1, mX_err=1, mX_rdata=16'hFFFF, -> IDLE.
//    s_ready on that same cycle wins (normal completion, err=0).
//  - Non-granted master: ready/err=0, rdata=0; its valid stays pending, not dropped.
//  - Master dropping valid mid-BUSY is illegal; arbiter keeps s_valid until completion.
//  - Reset mid-BUSY: IDLE on that edge, no ready pulse issued, pending slave ready ignored.
//  - mX_rdata/mX_err are 0 whenever mX_ready=0.
// STRUCTURE
//  - mem_bus_pkg: ADDR_W/DATA_W/STRB_W localparams, state_t enum {IDLE,BUSY},
//    typedef struct mem_req_t {addr,wdata,wstrb}.
//  - Sub-module rr_arb2: 2-input round-robin picker (req[1:0], last -> grant one-hot);
//    FSM, timeout counter and request/response muxing live in mem_bus_arbiter.
// TESTING (bench: slave model = banked RAM, ready 1 cycle after s_valid, self-clearing)
//  - m0 read 0xB000 (RAM 0x1234) alone -> s_valid at N+1, m0_ready at N+2, m0_rdata=0x1234, m0_err=0.
//  - m0 and m1 both write at cycle N after reset -> m0 served first, m1 next; RAM holds both
//    values; m1 never sees ready during m0 transaction.
//  - 4 back-to-back contended pairs -> grants alternate m0,m1,m0,m1..., no starvation.
//  - Slave with ready tied 0, TIMEOUT=8 -> granted master gets ready at 8th BUSY cycle,
//    err=1, rdata=0xFFFF; arbiter returns IDLE and serves the other master next.
//  - rst asserted while BUSY -> next cycle s_valid=0, s_wstrb=0, grant=0, no m*_ready pulse.
//  - m1 writes 0x0001 to 0xFFFE with m0 idle -> s_addr=0xFFFE, s_wstrb=2'b10, s_wdata=0x0001
//    for exactly the BUSY cycles; s_wstrb=0 in every IDLE cycle.

Source files
------------

// File: rtl/mem_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_pkg
// Purpose  : Shared widths, FSM state type and request bundle for the
//            two-master memory bus arbiter.
// Contents : ADDR_W / DATA_W / STRB_W, state_t, mem_req_t, timeout read data.
// Revision : 1.0 - initial release
// ============================================================================
package mem_bus_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int STRB_W = 2;

  // Read data returned to a master whose transaction was aborted.
  localparam logic [DATA_W-1:0] C_TIMEOUT_RDATA = {DATA_W{1'b1}};

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } mem_req_t;

endpackage
`default_nettype wire

// File: rtl/mem_bus_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-input round-robin picker. A lone requester always wins;
//            on contention the requester that did not win last time wins.
// Ports    : req   [1:0] in  - request vector (bit0 = m0, bit1 = m1)
//            last        in  - index of the previously granted master
//            grant [1:0] out - one-hot winner, 0 when no request
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Purpose  : Shares one valid/ready memory port between a core (m0) and a
//            loader/debug master (m1). One transaction in flight, round-robin
//            on contention, per-transaction timeout abort.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            m0_* / m1_* (valid, addr, wdata, wstrb in; ready, rdata, err out)
//            s_valid/s_addr/s_wdata/s_wstrb out, s_ready/s_rdata in - slave
//            grant [1:0] out          - one-hot owner of current transaction
// Params   : TIMEOUT - BUSY cycles before abort, 0 disables the timeout
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              m0_valid,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [STRB_W-1:0] m0_wstrb,
  output logic              m0_ready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,

  input  logic              m1_valid,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [STRB_W-1:0] m1_wstrb,
  output logic              m1_ready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,

  output logic              s_valid,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  output logic [STRB_W-1:0] s_wstrb,
  input  logic              s_ready,
  input  logic [DATA_W-1:0] s_rdata,

  output logic [1:0]        grant
);

  // Counter only has to reach TIMEOUT-1.
  localparam int CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int C_TO_INT = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] C_TO_LAST = CNT_W'(C_TO_INT);

  state_t           r_state;
  logic [1:0]       r_grant;
  logic             r_last;
  logic [CNT_W-1:0] r_count;

  logic [1:0] w_req;
  logic [1:0] w_pick;
  logic       w_busy;
  logic       w_timeout;
  logic       w_done;
  mem_req_t   w_m0_req;
  mem_req_t   w_m1_req;
  mem_req_t   w_sel_req;

  assign w_req = {m1_valid, m0_valid};

  rr_arb2 u_rr_arb2 (
    .req   (w_req),
    .last  (r_last),
    .grant (w_pick)
  );

  assign w_busy = (r_state == BUSY);

  // A slave ready in the final allowed cycle completes normally.
  assign w_timeout = w_busy && (TIMEOUT != 0) && !s_ready && (r_count == C_TO_LAST);
  assign w_done    = w_busy && (s_ready || w_timeout);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_grant <= 2'b00;
      r_last  <= 1'b1;
      r_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_req) begin
            r_grant <= w_pick;
            r_last  <= w_pick[1];
            r_count <= '0;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (w_done) begin
            r_grant <= 2'b00;
            r_state <= IDLE;
          end else if (TIMEOUT != 0) begin
            r_count <= r_count + 1'b1;
          end
        end
        default: begin
          r_grant <= 2'b00;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Request mux; slave lines are forced to zero while idle so a stale
  // nonzero strobe can never be sampled as a write.
  assign w_m0_req  = '{addr: m0_addr, wdata: m0_wdata, wstrb: m0_wstrb};
  assign w_m1_req  = '{addr: m1_addr, wdata: m1_wdata, wstrb: m1_wstrb};
  assign w_sel_req = r_grant[1] ? w_m1_req : w_m0_req;

  assign s_valid = w_busy;
  assign s_addr  = w_busy ? w_sel_req.addr  : '0;
  assign s_wdata = w_busy ? w_sel_req.wdata : '0;
  assign s_wstrb = w_busy ? w_sel_req.wstrb : '0;
  assign grant   = r_grant;

  // Response demux: only the owner sees ready; rdata/err are zero otherwise.
  assign m0_ready = w_done && r_grant[0];
  assign m1_ready = w_done && r_grant[1];
  assign m0_err   = m0_ready && w_timeout;
  assign m1_err   = m1_ready && w_timeout;
  assign m0_rdata = m0_ready ? (w_timeout ? C_TIMEOUT_RDATA : s_rdata) : '0;
  assign m1_rdata = m1_ready ? (w_timeout ? C_TIMEOUT_RDATA : s_rdata) : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_arbiter
// Purpose  : Self-checking bench for mem_bus_arbiter with a banked-RAM/MMIO
//            slave model and a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

  localparam int TO = 8;

  logic        clk;
  logic        rst;
  logic        m0_valid, m1_valid;
  logic [15:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [1:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m1_ready, m0_err, m1_err;
  logic [15:0] m0_rdata, m1_rdata;
  logic        s_valid, s_ready;
  logic [15:0] s_addr, s_wdata, s_rdata;
  logic [1:0]  s_wstrb;
  logic [1:0]  grant;

  int n_cmp  = 0;
  int n_fail = 0;

  mem_bus_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata), .grant(grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- slave model: RAM bank at 0xB0xx, MMIO at 0xFFFE -------
  logic [7:0]  ram [0:255];
  logic [15:0] mmio;
  bit          ram_init = 1'b0;
  bit          slave_dead;

  function automatic logic [15:0] slave_rd(input logic [15:0] a);
    if (a[15:8] == 8'hB0) return {ram[a[7:0] + 8'd1], ram[a[7:0]]};
    if (a == 16'hFFFE)    return mmio;
    return 16'h0000;
  endfunction

  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
      mmio     <= 16'h0000;
      ram_init <= 1'b1;
      s_ready  <= 1'b0;
      s_rdata  <= 16'h0000;
    end else if (s_valid && !s_ready && !slave_dead) begin
      s_ready <= 1'b1;
      s_rdata <= slave_rd(s_addr);
      if (s_addr[15:8] == 8'hB0) begin
        if (s_wstrb[1]) begin
          ram[s_addr[7:0]]        <= s_wdata[7:0];
          ram[s_addr[7:0] + 8'd1] <= s_wdata[15:8];
        end else if (s_wstrb[0]) begin
          ram[s_addr[7:0]] <= s_wdata[7:0];
        end
      end else if (s_addr == 16'hFFFE && s_wstrb != 2'b00) begin
        mmio <= s_wdata;
      end
    end else begin
      s_ready <= 1'b0;
      s_rdata <= 16'h0000;
    end
  end

  // ---------------- helpers ------------------------------------------------
  typedef struct {
    int          id;
    logic [15:0] rdata;
    logic        err;
  } comp_t;
  comp_t comp_q[$];

  logic [15:0] op_addr  [2][8];
  logic [15:0] op_wdata [2][8];
  logic [1:0]  op_wstrb [2][8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic v, input logic [15:0] a,
                         input logic [15:0] d, input logic [1:0] s);
    if (id == 0) begin
      m0_valid = v; m0_addr = a; m0_wdata = d; m0_wstrb = s;
    end else begin
      m1_valid = v; m1_addr = a; m1_wdata = d; m1_wstrb = s;
    end
  endtask

  // Issues n ops from the op tables for one master, back to back, holding
  // each request until ready and checking response-side rules every cycle.
  task automatic master_run(input int id, input int n);
    int          cyc;
    logic        rdy, other, er;
    logic [15:0] rd;
    comp_t       c;
    for (int k = 0; k < n; k++) begin
      set_req(id, 1'b1, op_addr[id][k], op_wdata[id][k], op_wstrb[id][k]);
      cyc = 0;
      rdy = 1'b0;
      while (!rdy && cyc < 40) begin
        @(negedge clk);
        cyc++;
        rdy   = (id == 1) ? m1_ready : m0_ready;
        other = (id == 1) ? m0_ready : m1_ready;
        rd    = (id == 1) ? m1_rdata : m0_rdata;
        er    = (id == 1) ? m1_err   : m0_err;
        n_cmp++;
        if (!rdy && (rd !== 16'h0000 || er !== 1'b0)) begin
          n_fail++;
          $display("FAIL quiet_resp m%0d: rdata=%h err=%b, required 0000/0", id, rd, er);
        end
        if (rdy) begin
          n_cmp++;
          if (grant !== ((id == 1) ? 2'b10 : 2'b01) || other !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_owner m%0d: grant=%b other_ready=%b, required owner only", id, grant, other);
          end
          c.id = id; c.rdata = rd; c.err = er;
          comp_q.push_back(c);
        end
      end
      if (!rdy) begin
        n_fail++;
        $display("FAIL wait_ready m%0d: no ready in 40 cycles, required completion", id);
      end
      tick();
    end
    set_req(id, 1'b0, 16'h0, 16'h0, 2'b00);
  endtask

  // ---------------- tests ---------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    set_req(0, 1'b1, 16'hB000, 16'h1111, 2'b10);
    set_req(1, 1'b1, 16'hB002, 16'h2222, 2'b10);
    repeat (3) tick();
    @(negedge clk);
    n_cmp++;
    if ({s_valid, s_wstrb, grant} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: s_valid=%b s_wstrb=%b grant=%b, required 0", s_valid, s_wstrb, grant);
    end
    n_cmp++;
    if ({s_addr, s_wdata} !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_bus: s_addr=%h s_wdata=%h, required 0", s_addr, s_wdata);
    end
    n_cmp++;
    if ({m0_ready, m0_err, m0_rdata, m1_ready, m1_err, m1_rdata} !== 36'h0) begin
      n_fail++;
      $display("FAIL reset_resp: m0 %b/%b/%h m1 %b/%b/%h, required all 0",
               m0_ready, m0_err, m0_rdata, m1_ready, m1_err, m1_rdata);
    end
    set_req(0, 1'b0, 16'h0, 16'h0, 2'b00);
    set_req(1, 1'b0, 16'h0, 16'h0, 2'b00);
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    op_addr[0][0] = 16'hB000; op_wdata[0][0] = 16'h1234; op_wstrb[0][0] = 2'b10;
    master_run(0, 1);
    set_req(0, 1'b1, 16'hB000, 16'h0, 2'b00);           // cycle N
    @(negedge clk);
    n_cmp++;
    if (s_valid !== 1'b0) begin
      n_fail++; $display("FAIL rd_lat_n: s_valid=%b, required 0", s_valid);
    end
    tick(); @(negedge clk);                               // N+1
    n_cmp++;
    if (s_valid !== 1'b1 || s_addr !== 16'hB000 || s_wstrb !== 2'b00 || grant !== 2'b01 || m0_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_lat_n1: v=%b a=%h s=%b g=%b rdy=%b, required 1/B000/00/01/0",
               s_valid, s_addr, s_wstrb, grant, m0_ready);
    end
    tick(); @(negedge clk);                               // N+2
    n_cmp++;
    if (m0_ready !== 1'b1 || m0_rdata !== 16'h1234 || m0_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_data: rdy=%b rdata=%h err=%b, required 1/1234/0", m0_ready, m0_rdata, m0_err);
    end
    tick();
    set_req(0, 1'b0, 16'h0, 16'h0, 2'b00);
    @(negedge clk);                                       // N+3
    n_cmp++;
    if (s_valid !== 1'b0 || grant !== 2'b00 || s_wstrb !== 2'b00) begin
      n_fail++;
      $display("FAIL rd_idle: v=%b g=%b s=%b, required 0/00/00", s_valid, grant, s_wstrb);
    end
    tick();
  endtask

  task automatic test_contended_write();
    rst = 1'b1; tick(); rst = 1'b0;
    set_req(0, 1'b1, 16'hB010, 16'hAAAA, 2'b10);          // cycle N
    set_req(1, 1'b1, 16'hB020, 16'h5555, 2'b10);
    @(negedge clk);
    tick(); @(negedge clk);                               // N+1
    n_cmp++;
    if (grant !== 2'b01 || s_addr !== 16'hB010 || s_wdata !== 16'hAAAA || m1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL cont_first: g=%b a=%h d=%h m1rdy=%b, required 01/B010/AAAA/0", grant, s_addr, s_wdata, m1_ready);
    end
    tick(); @(negedge clk);                               // N+2
    n_cmp++;
    if (m0_ready !== 1'b1 || m0_err !== 1'b0 || m1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL cont_m0_done: m0rdy=%b err=%b m1rdy=%b, required 1/0/0", m0_ready, m0_err, m1_ready);
    end
    tick();
    set_req(0, 1'b0, 16'h0, 16'h0, 2'b00);
    @(negedge clk);                                       // N+3
    n_cmp++;
    if (s_valid !== 1'b0 || grant !== 2'b00 || m1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL cont_gap: v=%b g=%b m1rdy=%b, required 0/00/0", s_valid, grant, m1_ready);
    end
    tick(); @(negedge clk);                               // N+4
    n_cmp++;
    if (grant !== 2'b10 || s_addr !== 16'hB020 || s_wdata !== 16'h5555) begin
      n_fail++;
      $display("FAIL cont_second: g=%b a=%h d=%h, required 10/B020/5555", grant, s_addr, s_wdata);
    end
    tick(); @(negedge clk);                               // N+5
    n_cmp++;
    if (m1_ready !== 1'b1 || m1_err !== 1'b0 || m0_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL cont_m1_done: m1rdy=%b err=%b m0rdy=%b, required 1/0/0", m1_ready, m1_err, m0_ready);
    end
    tick();
    set_req(1, 1'b0, 16'h0, 16'h0, 2'b00);
    tick();
    n_cmp++;
    if ({ram[8'h11], ram[8'h10], ram[8'h21], ram[8'h20]} !== 32'hAAAA5555) begin
      n_fail++;
      $display("FAIL cont_ram: B010=%h B020=%h, required AAAA/5555",
               {ram[8'h11], ram[8'h10]}, {ram[8'h21], ram[8'h20]});
    end
  endtask

  task automatic test_mmio_write();
    int  busy_cycles;
    bit  seen;
    busy_cycles = 0;
    seen = 1'b0;
    set_req(1, 1'b1, 16'hFFFE, 16'h0001, 2'b10);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++;
      if (grant !== 2'b00) begin
        busy_cycles++;
        if (s_valid !== 1'b1 || s_addr !== 16'hFFFE || s_wstrb !== 2'b10 || s_wdata !== 16'h0001) begin
          n_fail++;
          $display("FAIL mmio_busy: v=%b a=%h s=%b d=%h, required 1/FFFE/10/0001", s_valid, s_addr, s_wstrb, s_wdata);
        end
      end else if (s_valid !== 1'b0 || s_wstrb !== 2'b00 || s_addr !== 16'h0000) begin
        n_fail++;
        $display("FAIL mmio_idle: v=%b s=%b a=%h, required 0/00/0000", s_valid, s_wstrb, s_addr);
      end
      if (m1_ready === 1'b1) seen = 1'b1;
      tick();
      if (seen) set_req(1, 1'b0, 16'h0, 16'h0, 2'b00);
    end
    n_cmp++;
    if (busy_cycles != 2 || mmio !== 16'h0001) begin
      n_fail++;
      $display("FAIL mmio_result: busy_cycles=%0d mmio=%h, required 2/0001", busy_cycles, mmio);
    end
  endtask

  task automatic test_timeout();
    slave_dead = 1'b1;
    set_req(0, 1'b1, 16'hB000, 16'h0, 2'b00);             // cycle N
    set_req(1, 1'b1, 16'hB010, 16'h0, 2'b00);
    @(negedge clk);
    for (int i = 1; i <= TO; i++) begin
      tick(); @(negedge clk);
      n_cmp++;
      if (i < TO) begin
        if (m0_ready !== 1'b0 || m1_ready !== 1'b0 || grant !== 2'b01) begin
          n_fail++;
          $display("FAIL to_wait c%0d: m0rdy=%b m1rdy=%b g=%b, required 0/0/01", i, m0_ready, m1_ready, grant);
        end
      end else if (m0_ready !== 1'b1 || m0_err !== 1'b1 || m0_rdata !== 16'hFFFF || m1_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL to_abort: rdy=%b err=%b rdata=%h m1rdy=%b, required 1/1/FFFF/0",
                 m0_ready, m0_err, m0_rdata, m1_ready);
      end
    end
    tick();
    set_req(0, 1'b0, 16'h0, 16'h0, 2'b00);
    slave_dead = 1'b0;
    @(negedge clk);                                       // N+9
    n_cmp++;
    if (s_valid !== 1'b0 || grant !== 2'b00) begin
      n_fail++; $display("FAIL to_idle: v=%b g=%b, required 0/00", s_valid, grant);
    end
    tick(); @(negedge clk);                               // N+10
    n_cmp++;
    if (grant !== 2'b10) begin
      n_fail++; $display("FAIL to_next_grant: g=%b, required 10", grant);
    end
    tick(); @(negedge clk);                               // N+11
    n_cmp++;
    if (m1_ready !== 1'b1 || m1_err !== 1'b0 || m1_rdata !== 16'hAAAA) begin
      n_fail++;
      $display("FAIL to_next_done: rdy=%b err=%b rdata=%h, required 1/0/AAAA", m1_ready, m1_err, m1_rdata);
    end
    tick();
    set_req(1, 1'b0, 16'h0, 16'h0, 2'b00);
    tick();
  endtask

  task automatic test_reset_mid_busy();
    set_req(1, 1'b1, 16'hB010, 16'h0, 2'b00);             // cycle N
    tick();                                               // N+1 (BUSY)
    rst = 1'b1;
    set_req(1, 1'b0, 16'h0, 16'h0, 2'b00);
    @(negedge clk);
    n_cmp++;
    if (s_valid !== 1'b1 || grant !== 2'b10) begin
      n_fail++; $display("FAIL rstb_busy: v=%b g=%b, required 1/10", s_valid, grant);
    end
    tick();                                               // N+2, slave ready pending
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if (s_valid !== 1'b0 || s_wstrb !== 2'b00 || grant !== 2'b00 || m0_ready !== 1'b0 || m1_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL rstb_after c%0d: v=%b s=%b g=%b rdy=%b%b, required all 0",
                 i, s_valid, s_wstrb, grant, m1_ready, m0_ready);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ref_w [logic [15:0]];
    logic [15:0] a, d, old;
    logic [1:0]  s;
    int          exp_id, model_last, sel;
    int          idx[2];
    comp_t       c;
    rst = 1'b1; tick(); rst = 1'b0;
    model_last = 1;
    for (int round = 0; round < 2; round++) begin
      for (int id = 0; id < 2; id++) begin
        for (int k = 0; k < 4; k++) begin
          op_addr[id][k]  = 16'hB040 + 16'(2 * $urandom_range(0, 7));
          op_wdata[id][k] = 16'($urandom);
          sel = $urandom_range(0, 2);
          op_wstrb[id][k] = (sel == 0) ? 2'b00 : (sel == 1) ? 2'b10 : 2'b01;
        end
      end
      comp_q.delete();
      fork
        master_run(0, 4);
        master_run(1, 4);
      join
      n_cmp++;
      if (comp_q.size() != 8) begin
        n_fail++; $display("FAIL b2b_count r%0d: %0d completions, required 8", round, comp_q.size());
      end
      exp_id = (model_last == 1) ? 0 : 1;
      idx[0] = 0; idx[1] = 0;
      for (int j = 0; j < comp_q.size() && j < 8; j++) begin
        c = comp_q[j];
        a = op_addr[exp_id][idx[exp_id]];
        d = op_wdata[exp_id][idx[exp_id]];
        s = op_wstrb[exp_id][idx[exp_id]];
        idx[exp_id]++;
        old = ref_w.exists(a) ? ref_w[a] : 16'h0000;
        n_cmp++;
        if (c.id != exp_id || c.err !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_order r%0d #%0d: master m%0d err=%b, required m%0d err=0", round, j, c.id, c.err, exp_id);
        end
        if (s == 2'b00) begin
          n_cmp++;
          if (c.rdata !== old) begin
            n_fail++;
            $display("FAIL b2b_rdata r%0d #%0d @%h: got %h, required %h", round, j, a, c.rdata, old);
          end
        end else begin
          ref_w[a] = (s == 2'b10) ? d : {old[15:8], d[7:0]};
        end
        model_last = exp_id;
        exp_id = 1 - exp_id;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    slave_dead = 1'b0;
    set_req(0, 1'b0, 16'h0, 16'h0, 2'b00);
    set_req(1, 1'b0, 16'h0, 16'h0, 2'b00);
    test_reset();
    test_single_read();
    test_contended_write();
    test_mmio_write();
    test_timeout();
    test_reset_mid_busy();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
